ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-port SRAM arbiter and stall sequencer for the 16-bit five-stage pipeline. Instruction fetch (IF) and the MEM stage share one external SRAM. The block grants the RAM to one requester at a time and runs a fixed multi-cycle access. While a requester waits, it drives the per-stage `stall` bits that freeze the pipeline registers (pc, if_id, id_ex, ex_mem, mem_wb).

## Interface
- `ACC_CYCLES`, default 2: SRAM access length in cycles, ≥1.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset (`RstEnable` = 0).
- `if_req`  in  1  IF wants an instruction word.
- `if_addr`  in  16  IF word address.
- `if_rdata`  out  16  fetched word, valid while `if_ready`.
- `if_ready`  out  1  one-cycle completion pulse for IF.
- `mem_req`  in  1  MEM-stage load/store request.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  16  MEM word address.
- `mem_wdata`  in  16  store data.
- `mem_rdata`  out  16  load data, valid while `mem_ready`.
- `mem_ready`  out  1  one-cycle completion pulse for MEM.
- `ram_addr`  out  16  SRAM address.
- `ram_wdata`  out  16  SRAM write data.
- `ram_rdata`  in  16  SRAM read data.
- `ram_en_n`  out  1  chip enable, active low.
- `ram_oe_n`  out  1  output enable, active low.
- `ram_we_n`  out  1  write enable, active low.
- `stall`  out  5  [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb; 1 = `StallYes`.

## Operation
- States:
  - IDLE: no access.
  - IF_ACC: IF access in progress.
  - MEM_ACC: MEM access in progress.
  - Counter `cnt` runs 0..ACC_CYCLES-1 in the ACC states.
- Eligibility: a requester is eligible when its req is high and its ready is low this cycle. This prevents re-granting the request that is just completing.
- Grant is evaluated in IDLE and on the final ACC cycle, so accesses run back-to-back with no idle cycle.
- Grant priority:
  - MEM beats IF (older instruction).
  - Exception: if the access just finishing was MEM and IF is eligible, IF wins (anti-starvation).
- At grant, the address, `mem_we` and `mem_wdata` are latched. Later input changes are ignored until the next grant.
- In the ACC states:
  - `ram_en_n` = 0.
  - Read: `ram_oe_n` = 0, `ram_we_n` = 1.
  - Write: `ram_oe_n` = 1, `ram_we_n` = 0 for all ACC_CYCLES cycles.
  - `ram_addr`/`ram_wdata` come from the latched values.
- On the edge ending the final ACC cycle:
  - `ram_rdata` is registered into the owner's rdata.
  - The owner's ready goes high for exactly the next cycle.
  - rdata holds until the next completion of that requester.
  - Store completion pulses `mem_ready`; `mem_rdata` is unchanged.
- Stall (combinational from state, requests and ready):
  - MEM eligible → `stall` = 5'b11111. A mem_wb hold re-issues the same writeback, which is idempotent.
  - else IF eligible → `stall` = 5'b00011. id_ex receives a bubble through its own logic.
  - else `stall` = 5'b00000.
- Withdrawn request: if req drops mid-access, the access still completes and the ready pulse is issued and ignored.
- Outside the ACC states: `ram_en_n` = `ram_oe_n` = `ram_we_n` = 1.

## Timing
- Latency: req first seen high at cycle N in IDLE → RAM driven cycles N+1..N+ACC_CYCLES → ready high at cycle N+ACC_CYCLES+1. Stall is high from cycle N through cycle N+ACC_CYCLES and low in the ready cycle, so the pipeline advances on that edge.
- Back-to-back: the second access's RAM cycles start the cycle after the first's final cycle. Ready for the first coincides with the second's first RAM cycle.
- Reset values: state IDLE, `cnt` 0, `ram_en_n`/`ram_oe_n`/`ram_we_n` = 1, `ram_addr`/`ram_wdata` 0, `if_rdata`/`mem_rdata` 0, `if_ready`/`mem_ready` 0, `stall` 0.
- Reset asserted mid-access aborts immediately with all outputs at reset values. No ready pulse is issued for the aborted access.
- `rst` deassertion is sampled on `clk`. The first grant can occur in the first cycle after release.

## Test plan
- **Reset:** `rst`=0 during a MEM read → `ram_en_n`/`ram_oe_n`/`ram_we_n` = 1, `stall`=0, ready=0 immediately. `rst`=1 then `if_req`=1, `if_addr`=0x0010, `ram_rdata`=0x1234 → `if_ready` at cycle +3, `if_rdata`=0x1234, `stall`=00011 for 3 cycles.
- **Simultaneous requests:** `if_req`=`mem_req`=1, `mem_we`=0, `mem_addr`=0x8000 → MEM granted first, `stall`=11111. `mem_ready` at +3. IF RAM cycles start at +3 with `ram_addr`=IF address. `if_ready` at +5.
- **Store:** `mem_we`=1, `mem_addr`=0x8004, `mem_wdata`=0xBEEF → `ram_we_n`=0 and `ram_oe_n`=1 for 2 cycles with `ram_addr`=0x8004, `ram_wdata`=0xBEEF. `mem_ready` pulses once; `mem_rdata` unchanged.
- **Anti-starvation:** `mem_req` held high continuously plus `if_req` → grants alternate MEM, IF, MEM. `mem_ready` never re-grants in its own pulse cycle.
- **Latch and withdraw:** change `mem_addr` mid-access → `ram_addr` keeps the latched value. Drop `if_req` mid-access → access completes, `if_ready` pulses, then IDLE.
- **Reset mid-access:** assert `rst` during `cnt`=0 of IF_ACC → no `if_ready`. After release, a new request behaves as from cold.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one SRAM between IF and MEM with fixed-length accesses
// and drives the pipeline stall bits while a requester waits.
module ram_arbiter #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_en_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic [4:0]  stall
);
  localparam int CW = ACC_CYCLES > 1 ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0] r_addr, r_wdata;
  logic r_we;
  logic w_if_elig, w_mem_elig, w_acc, w_last, w_grant, w_if_done, w_mem_done;
  // a requester whose ready is pulsing is not eligible, so its stall drops in the ready cycle
  assign w_if_elig = if_req & ~if_ready;
  assign w_mem_elig = mem_req & ~mem_ready;
  assign w_acc = r_state != IDLE;
  assign w_last = w_acc && r_cnt == LAST;
  assign w_grant = !w_acc || w_last;
  assign w_if_done = w_last && r_state == IF_ACC;
  assign w_mem_done = w_last && r_state == MEM_ACC;
  assign ram_addr = r_addr;
  assign ram_wdata = r_wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_acc && !w_last) ? r_cnt + 1'b1 : '0;
    end
  // MEM normally wins; IF wins right after a MEM access so it cannot starve
  always_comb begin
    w_next = r_state;
    if (w_grant)
      w_next = (r_state == MEM_ACC && w_if_elig) ? IF_ACC :
               w_mem_elig ? MEM_ACC :
               w_if_elig ? IF_ACC : IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_addr <= '0;
      r_wdata <= '0;
      r_we <= 1'b0;
      if_rdata <= '0;
      mem_rdata <= '0;
      if_ready <= 1'b0;
      mem_ready <= 1'b0;
    end else begin
      if (w_grant && w_next != IDLE) begin
        r_addr <= w_next == MEM_ACC ? mem_addr : if_addr;
        r_we <= w_next == MEM_ACC && mem_we;
        r_wdata <= mem_wdata;
      end
      if_ready <= w_if_done;
      mem_ready <= w_mem_done;
      if (w_if_done) if_rdata <= ram_rdata;
      if (w_mem_done && !r_we) mem_rdata <= ram_rdata;
    end
  always_comb begin
    ram_en_n = !w_acc;
    ram_oe_n = !(w_acc && !r_we);
    ram_we_n = !(w_acc && r_we);
    stall = !rst ? 5'b00000 : w_mem_elig ? 5'b11111 : w_if_elig ? 5'b00011 : 5'b00000;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios checked every cycle against a transaction-level
// owner/countdown model, plus hand-computed literal expectations.
module tb_ram_arbiter;
  localparam int ACC = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [15:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, ram_rdata = '0;
  logic [15:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic if_ready, mem_ready, ram_en_n, ram_oe_n, ram_we_n;
  logic [4:0] stall;
  int n_tests = 0, n_fail = 0;

  ram_arbiter #(.ACC_CYCLES(ACC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .stall(stall)
  );

  always #5 clk = ~clk;

  // model: owner 0 none / 1 IF / 2 MEM, with cycles left in its access
  int m_own = 0, m_left = 0, m_pick = 0;
  bit m_ie, m_me, m_fin;
  logic m_we = 1'b0;
  logic [15:0] m_addr = '0, m_wdata = '0, e_if_rdata = '0, e_mem_rdata = '0;
  logic e_if_ready = 1'b0, e_mem_ready = 1'b0;
  int grants[$];

  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_own = 0; m_left = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      e_if_rdata = '0; e_mem_rdata = '0; e_if_ready = 1'b0; e_mem_ready = 1'b0;
    end else begin
      m_ie = if_req && !e_if_ready;
      m_me = mem_req && !e_mem_ready;
      m_fin = m_own != 0 && m_left == 1;
      if (m_fin && m_own == 1) e_if_rdata = ram_rdata;
      if (m_fin && m_own == 2 && !m_we) e_mem_rdata = ram_rdata;
      e_if_ready = m_fin && m_own == 1;
      e_mem_ready = m_fin && m_own == 2;
      if (m_own == 0 || m_fin) begin
        m_pick = (m_own == 2 && m_ie) ? 1 : m_me ? 2 : m_ie ? 1 : 0;
        if (m_pick == 2) begin m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata; end
        if (m_pick == 1) begin m_addr = if_addr; m_we = 1'b0; end
        if (m_pick != 0) grants.push_back(m_pick);
        m_own = m_pick;
        m_left = ACC;
      end else m_left = m_left - 1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    logic [4:0] e_stall;
    e_stall = !rst ? 5'h00 : (mem_req && !e_mem_ready) ? 5'h1f : (if_req && !e_if_ready) ? 5'h03 : 5'h00;
    chk("ram_en_n", ram_en_n, m_own == 0);
    chk("ram_oe_n", ram_oe_n, !(m_own != 0 && !m_we));
    chk("ram_we_n", ram_we_n, !(m_own != 0 && m_we));
    chk("ram_addr", ram_addr, m_addr);
    if (m_own == 2 && m_we) chk("ram_wdata", ram_wdata, m_wdata);
    chk("if_ready", if_ready, e_if_ready);
    chk("mem_ready", mem_ready, e_mem_ready);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("mem_rdata", mem_rdata, e_mem_rdata);
    chk("stall", stall, e_stall);
  endtask

  task automatic half(); @(negedge clk); cmp_model(); endtask
  task automatic adv(); @(posedge clk); #1; endtask
  task automatic tick(); half(); adv(); endtask

  int g0;
  initial begin
    adv(); tick();
    half(); chk("rst_en", ram_en_n, 1); chk("rst_addr", ram_addr, 0); chk("rst_stall", stall, 0); adv();
    // reset aborts a MEM read
    rst = 1'b1; tick();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0040; ram_rdata = 16'hAAAA;
    half(); chk("s1_stall", stall, 5'h1f); adv();
    half(); chk("s1_en", ram_en_n, 0); chk("s1_oe", ram_oe_n, 0);
    #1 rst = 1'b0;
    #1 chk("s1_rst_en", ram_en_n, 1); chk("s1_rst_oe", ram_oe_n, 1); chk("s1_rst_we", ram_we_n, 1);
    chk("s1_rst_stall", stall, 0); chk("s1_rst_rdy", mem_ready, 0);
    adv(); mem_req = 1'b0; tick(); tick();
    // cold IF fetch
    rst = 1'b1; if_req = 1'b1; if_addr = 16'h0010; ram_rdata = 16'h1234;
    half(); chk("s2_stall0", stall, 5'h03); chk("s2_en0", ram_en_n, 1); adv();
    half(); chk("s2_stall1", stall, 5'h03); chk("s2_addr", ram_addr, 16'h0010); chk("s2_oe", ram_oe_n, 0); adv();
    if_req = 1'b0; tick();
    half(); chk("s2_rdy", if_ready, 1); chk("s2_rdata", if_rdata, 16'h1234); chk("s2_stall3", stall, 0); adv();
    tick();
    // simultaneous requests
    if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h8000; if_addr = 16'h0020; ram_rdata = 16'h5A5A;
    half(); chk("s3_stall", stall, 5'h1f); adv();
    half(); chk("s3_addr_m", ram_addr, 16'h8000); adv();
    tick();
    mem_req = 1'b0; ram_rdata = 16'h0F0F;
    half(); chk("s3_mrdy", mem_ready, 1); chk("s3_mrdata", mem_rdata, 16'h5A5A);
    chk("s3_addr_i", ram_addr, 16'h0020); chk("s3_stall3", stall, 5'h03); adv();
    if_req = 1'b0; tick();
    half(); chk("s3_irdy", if_ready, 1); chk("s3_irdata", if_rdata, 16'h0F0F); chk("s3_idle", ram_en_n, 1); adv();
    tick();
    // store with inputs changed mid-access
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8004; mem_wdata = 16'hBEEF; ram_rdata = 16'hDEAD;
    tick();
    mem_addr = 16'h9999; mem_wdata = 16'h1111; mem_we = 1'b0;
    half(); chk("s4_addr", ram_addr, 16'h8004); chk("s4_wdata", ram_wdata, 16'hBEEF);
    chk("s4_we", ram_we_n, 0); chk("s4_oe", ram_oe_n, 1); adv();
    mem_req = 1'b0;
    half(); chk("s4_we2", ram_we_n, 0); chk("s4_addr2", ram_addr, 16'h8004); adv();
    half(); chk("s4_rdy", mem_ready, 1); chk("s4_rdata", mem_rdata, 16'h5A5A); chk("s4_we3", ram_we_n, 1); adv();
    half(); chk("s4_rdy_off", mem_ready, 0); adv();
    // anti-starvation with mem_req held
    g0 = grants.size();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0100; if_req = 1'b1; if_addr = 16'h0200; ram_rdata = 16'h1111;
    tick();
    half(); chk("s5_addr1", ram_addr, 16'h0100); adv();
    tick();
    half(); chk("s5_mrdy", mem_ready, 1); chk("s5_addr3", ram_addr, 16'h0200); chk("s5_stall3", stall, 5'h03); adv();
    tick();
    if_req = 1'b0; mem_req = 1'b0;
    half(); chk("s5_irdy", if_ready, 1); chk("s5_addr5", ram_addr, 16'h0100); chk("s5_oe5", ram_oe_n, 0); adv();
    tick();
    half(); chk("s5_mrdy2", mem_ready, 1); adv();
    tick();
    chk("s5_ngrant", grants.size() - g0, 3);
    chk("s5_order", grants[g0] * 100 + grants[g0 + 1] * 10 + grants[g0 + 2], 212);
    // IF latch and withdraw
    if_req = 1'b1; if_addr = 16'h0300; ram_rdata = 16'h7777;
    tick();
    if_req = 1'b0; if_addr = 16'h0400;
    half(); chk("s6_addr", ram_addr, 16'h0300); chk("s6_stall", stall, 0); adv();
    tick();
    half(); chk("s6_rdy", if_ready, 1); chk("s6_rdata", if_rdata, 16'h7777); adv();
    half(); chk("s6_idle", ram_en_n, 1); adv();
    // reset during the first IF cycle, then cold restart
    if_req = 1'b1; if_addr = 16'h0500; ram_rdata = 16'h9999;
    tick();
    half(); chk("s7_en", ram_en_n, 0);
    #1 rst = 1'b0;
    #1 chk("s7_rst_en", ram_en_n, 1); chk("s7_rst_stall", stall, 0); chk("s7_rst_rdy", if_ready, 0);
    chk("s7_rst_rdata", if_rdata, 0); chk("s7_rst_addr", ram_addr, 0);
    adv(); if_req = 1'b0; tick(); tick();
    rst = 1'b1; if_req = 1'b1; if_addr = 16'h0600; ram_rdata = 16'h4242;
    half(); chk("s7_stall", stall, 5'h03); adv();
    half(); chk("s7_addr", ram_addr, 16'h0600); adv();
    if_req = 1'b0; tick();
    half(); chk("s7_rdy", if_ready, 1); chk("s7_rdata", if_rdata, 16'h4242); adv();
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
